// File: rtl/sign_narrower.sv
// Narrows an n-bit word to m bits (signed or unsigned), flags overflow, and queues results in a 2-entry FIFO.
// Optional macro SIGN_NARROWER_SAT_EN saturates overflowing results instead of truncating them.
module sign_narrower #(
    parameter int m = 4,
    parameter int n = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [n-1:0] in_data,
    input  logic         in_sgn,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [m-1:0] out_data,
    output logic         out_ovf,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [15:0]  ovf_cnt,
    input  logic         ovf_clr
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } occ_t;

    occ_t         state, state_nxt;
    logic [m-1:0] head_data, head_data_nxt;
    logic         head_ovf, head_ovf_nxt;
    logic [m-1:0] tail_data, tail_data_nxt;
    logic         tail_ovf, tail_ovf_nxt;

    logic         accept, pop;
    logic [n-m:0] sgn_field;
    logic [n-m-1:0] uns_field;
    logic         ovf;
    logic [m-1:0] result;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_data  = out_valid ? head_data : '0;
    assign out_ovf   = out_valid ? head_ovf  : 1'b0;

    assign sgn_field = in_data[n-1:m-1];
    assign uns_field = in_data[n-1:m];

    // A signed value fits when every bit above the new sign bit replicates it.
    always_comb begin
        if (in_sgn) begin
            ovf = !((&sgn_field) || !(|sgn_field));
        end else begin
            ovf = |uns_field;
        end
    end

    always_comb begin
        result = in_data[m-1:0];
`ifdef SIGN_NARROWER_SAT_EN
        if (ovf) begin
            if (in_sgn) begin
                result = in_data[n-1] ? {1'b1, {(m-1){1'b0}}} : {1'b0, {(m-1){1'b1}}};
            end else begin
                result = '1;
            end
        end
`endif
    end

    always_comb begin
        state_nxt     = state;
        head_data_nxt = head_data;
        head_ovf_nxt  = head_ovf;
        tail_data_nxt = tail_data;
        tail_ovf_nxt  = tail_ovf;
        case (state)
            EMPTY: begin
                if (accept) begin
                    head_data_nxt = result;
                    head_ovf_nxt  = ovf;
                    state_nxt     = ONE;
                end
            end
            ONE: begin
                // Push and pop together replace the head in place, keeping order.
                if (accept && pop) begin
                    head_data_nxt = result;
                    head_ovf_nxt  = ovf;
                end else if (accept) begin
                    tail_data_nxt = result;
                    tail_ovf_nxt  = ovf;
                    state_nxt     = FULL;
                end else if (pop) begin
                    state_nxt     = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_data_nxt = tail_data;
                    head_ovf_nxt  = tail_ovf;
                    state_nxt     = ONE;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            head_data <= '0;
            head_ovf  <= 1'b0;
            tail_data <= '0;
            tail_ovf  <= 1'b0;
        end else begin
            state     <= state_nxt;
            head_data <= head_data_nxt;
            head_ovf  <= head_ovf_nxt;
            tail_data <= tail_data_nxt;
            tail_ovf  <= tail_ovf_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt <= '0;
        end else if (ovf_clr) begin
            ovf_cnt <= '0;
        end else if (accept && ovf && (ovf_cnt != 16'hFFFF)) begin
            ovf_cnt <= ovf_cnt + 16'd1;
        end
    end

endmodule
